mcu_reg_bridge: RTL and testbench
=================================

Name: mcu_reg_bridge

Overview:
- Stage directly upstream of the control register file. Converts the asynchronous MCU memory-bus strobes into a clocked access sequence on the register-file bus: en/rd/wr/be/addr/data.
- Write sequence: en rises, wr pulses, wr falls while en is still high. The register file commits on the wr falling edge.
- Read sequence: en rises, rd rises (the register file latches on the en&rd rising edge), then read data is captured.
- Stretches the MCU cycle with a wait signal until the access has completed.

Parameters:
- ADDR_WIDTH, 8, register address width.
- DATA_WIDTH, 16, data bus width; fixed at 16 because be is 2 bits.
- STROBE_CYCLES, 2, clocks for which reg_rd/reg_wr are held high; legal range 1..15.
- SYNC_STAGES, 2, synchronizer depth on the MCU strobes; minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mcu_ncs  in  1  chip select, active low
- mcu_nrd  in  1  read strobe, active low
- mcu_nwr  in  1  write strobe, active low
- mcu_be  in  2  byte enables: bit0 = [7:0], bit1 = [15:8]
- mcu_addr  in  ADDR_WIDTH  MCU address
- mcu_din  in  DATA_WIDTH  MCU write data
- mcu_dout  out  DATA_WIDTH  registered read data to the MCU
- mcu_doe  out  1  MCU data-bus output enable
- mcu_wait  out  1  wait/stretch request to the MCU
- reg_en  out  1  register-file access enable
- reg_rd  out  1  register-file read strobe
- reg_wr  out  1  register-file write strobe
- reg_be  out  2  register-file byte enables
- reg_addr  out  ADDR_WIDTH  register-file address
- reg_wdata  out  DATA_WIDTH  register-file write data
- reg_rdata  in  DATA_WIDTH  register-file read data
- proto_err  out  1  sticky protocol-error flag
- err_clr  in  1  clears proto_err

Behaviour:
- Reset: all outputs go to 0 asynchronously and the state goes to IDLE. Every output is registered.
- Synchronization:
  - cs_rd = ~mcu_ncs & ~mcu_nrd and cs_wr = ~mcu_ncs & ~mcu_nwr, each passed through SYNC_STAGES flops, giving s_rd and s_wr.
  - mcu_addr, mcu_be and mcu_din are sampled only on the IDLE->ADDR transition. The MCU holds them stable from strobe fall until mcu_wait falls.
- FSM states: IDLE, ADDR, STROBE, RELEASE, DONE. Edge E0 is the clock edge at which IDLE sees s_rd or s_wr.
  - IDLE, with exactly one of s_rd/s_wr set: at E0 latch addr/be/din and the direction; set reg_en=1 and mcu_wait=1; go to ADDR.
  - IDLE, with s_rd and s_wr both set: do not access the register file; set proto_err=1; go to DONE. mcu_wait stays 0.
  - ADDR, at E1: reg_rd or reg_wr = 1 per direction; go to STROBE; load the strobe counter with STROBE_CYCLES-1.
  - STROBE: decrement the counter each clock. At the edge where the counter is 0 (E1+STROBE_CYCLES): reg_rd=reg_wr=0, keep reg_en=1, go to RELEASE.
  - RELEASE, at E2+STROBE_CYCLES:
    - reg_en=0 and mcu_wait=0; go to DONE.
    - For a read: mcu_dout <= reg_rdata and mcu_doe=1.
- DONE: stay until s_rd=0 and s_wr=0, then mcu_doe=0 and go to IDLE.
- mcu_wait latency: rises SYNC_STAGES+1 clocks after the strobe falls. The MCU samples wait no earlier than that.
- Strobe ordering guarantees:
  - reg_rd and reg_wr are never high together.
  - reg_en is high for one full clock before any strobe rises and for one full clock after it falls.
  - reg_addr, reg_be and reg_wdata are held from ADDR through the end of DONE.
- MCU deasserting the strobe mid-access: the access always runs to completion (no abort). DONE then exits immediately.
- Direction swap while in DONE (e.g. nrd released and nwr asserted): DONE exits only when both synced strobes are low. The new access starts from IDLE.
- Reset mid-access: reg_wr drops asynchronously. This is acceptable because the register file is reset by the same reset.
- proto_err: sticky. err_clr clears it on the next clock; a set and a clear in the same cycle resolves to set.

Decomposition:
- Header mcu_reg_bridge.vh: the FSM state encodings (3-bit) and the direction codes DIR_RD/DIR_WR. Included in the same way as registers.vh.
- One sub-module, cc_sync: a SYNC_STAGES-deep single-bit synchronizer with active-low async reset to 0. Instantiated twice.

Test Plan (STROBE_CYCLES=2, SYNC_STAGES=2):
- Write of 0xBEEF to addr 0x05 with be=2'b11:
  - reg_en high E0..E3; reg_wr high for exactly 2 clocks (E1..E2); falls at E3 while reg_en=1.
  - mcu_wait falls at E4; the register-file model then holds 0xBEEF.
- Read of addr 0x05 with the model returning 0xBEEF:
  - reg_rd high for 2 clocks inside reg_en.
  - mcu_dout=0xBEEF and mcu_doe=1 from E4; mcu_doe clears 1 clock after the synced nrd deasserts.
- Byte write with be=2'b01, data 0x1234: reg_be=01 during the access; the model low byte becomes 0x34 and the high byte is unchanged.
- nrd and nwr asserted together: reg_en, reg_rd and reg_wr stay 0; proto_err=1 until err_clr, then 0 the next clock.
- MCU releases nwr at E2 (mid-access): the strobe still completes 2 clocks; FSM returns to IDLE by E5; a following read starts normally.
- reset asserted at E2 of a write: all outputs are 0 within the same cycle (asynchronous); state is IDLE; after release the bridge is idle until a new strobe arrives.

Source files
------------

// File: rtl/mcu_reg_bridge_pkg.sv
// Shared types and constants for the MCU-to-register-file bridge.
// Holds the FSM state encodings and the access direction codes.
package mcu_reg_bridge_pkg;

  localparam int unsigned STATE_WIDTH = 3;
  localparam int unsigned CNT_WIDTH   = 4;
  localparam int unsigned BE_WIDTH    = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_STROBE  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  // Strobe counter preload: counts down to zero over the strobe-high window.
  function automatic logic [CNT_WIDTH-1:0] strobe_load(input int unsigned cycles);
    return CNT_WIDTH'(cycles - 1);
  endfunction

endpackage

// File: rtl/mcu_reg_bridge_if.sv
// MCU memory-bus bundle: active-low strobes, address/data/byte enables,
// and the bridge's read-data, output-enable and wait responses.
interface mcu_reg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  import mcu_reg_bridge_pkg::*;

  logic                  mcu_ncs;
  logic                  mcu_nrd;
  logic                  mcu_nwr;
  logic [BE_WIDTH-1:0]   mcu_be;
  logic [ADDR_WIDTH-1:0] mcu_addr;
  logic [DATA_WIDTH-1:0] mcu_din;
  logic [DATA_WIDTH-1:0] mcu_dout;
  logic                  mcu_doe;
  logic                  mcu_wait;

  // The MCU side drives strobes and write payload.
  modport master (
    output mcu_ncs, mcu_nrd, mcu_nwr, mcu_be, mcu_addr, mcu_din,
    input  mcu_dout, mcu_doe, mcu_wait
  );

  // The bridge side returns read data and wait.
  modport slave (
    input  mcu_ncs, mcu_nrd, mcu_nwr, mcu_be, mcu_addr, mcu_din,
    output mcu_dout, mcu_doe, mcu_wait
  );

endinterface

// File: rtl/cc_sync.sv
// Single-bit multi-flop synchronizer, asynchronously cleared to 0.
// STAGES must be at least 2.
module cc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/mcu_reg_bridge.sv
// Converts asynchronous MCU bus strobes into a clocked en/rd/wr access on the
// register-file bus, stretching the MCU cycle with wait until it completes.
module mcu_reg_bridge
  import mcu_reg_bridge_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mcu_reg_bridge_if.slave       mcu,
  output logic                  reg_en,
  output logic                  reg_rd,
  output logic                  reg_wr,
  output logic [BE_WIDTH-1:0]   reg_be,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  proto_err,
  input  logic                  err_clr
);

  logic cs_rd_c;
  logic cs_wr_c;
  logic s_rd;
  logic s_wr;

  state_e               state_q;
  state_e               state_d;
  dir_e                 dir_q;
  dir_e                 dir_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  logic                  reg_en_d;
  logic                  reg_rd_d;
  logic                  reg_wr_d;
  logic [BE_WIDTH-1:0]   reg_be_d;
  logic [ADDR_WIDTH-1:0] reg_addr_d;
  logic [DATA_WIDTH-1:0] reg_wdata_d;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  doe_d;
  logic                  wait_d;
  logic                  err_set;
  logic                  err_d;

  assign cs_rd_c = ~mcu.mcu_ncs & ~mcu.mcu_nrd;
  assign cs_wr_c = ~mcu.mcu_ncs & ~mcu.mcu_nwr;

  cc_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk   (clk),
    .reset (reset),
    .d     (cs_rd_c),
    .q     (s_rd)
  );

  cc_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk   (clk),
    .reset (reset),
    .d     (cs_wr_c),
    .q     (s_wr)
  );

  // Next-state and next-output logic; every output holds unless a state changes it.
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    cnt_d       = cnt_q;
    reg_en_d    = reg_en;
    reg_rd_d    = reg_rd;
    reg_wr_d    = reg_wr;
    reg_be_d    = reg_be;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    dout_d      = mcu.mcu_dout;
    doe_d       = mcu.mcu_doe;
    wait_d      = mcu.mcu_wait;
    err_set     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_rd && s_wr) begin
          // Both strobes at once is illegal: flag it and skip the register file.
          err_set = 1'b1;
          state_d = ST_DONE;
        end else if (s_rd || s_wr) begin
          dir_d       = s_wr ? DIR_WR : DIR_RD;
          reg_addr_d  = mcu.mcu_addr;
          reg_be_d    = mcu.mcu_be;
          reg_wdata_d = mcu.mcu_din;
          reg_en_d    = 1'b1;
          wait_d      = 1'b1;
          state_d     = ST_ADDR;
        end
      end

      ST_ADDR: begin
        reg_rd_d = (dir_q == DIR_RD);
        reg_wr_d = (dir_q == DIR_WR);
        cnt_d    = strobe_load(STROBE_CYCLES);
        state_d  = ST_STROBE;
      end

      ST_STROBE: begin
        if (cnt_q == '0) begin
          reg_rd_d = 1'b0;
          reg_wr_d = 1'b0;
          state_d  = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end

      ST_RELEASE: begin
        reg_en_d = 1'b0;
        wait_d   = 1'b0;
        if (dir_q == DIR_RD) begin
          dout_d = reg_rdata;
          doe_d  = 1'b1;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        // Wait for the MCU to drop both strobes before accepting a new access.
        if (!s_rd && !s_wr) begin
          doe_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sticky error: a set in the same cycle as a clear wins.
    err_d = err_set | (proto_err & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_RD;
      cnt_q        <= '0;
      reg_en       <= 1'b0;
      reg_rd       <= 1'b0;
      reg_wr       <= 1'b0;
      reg_be       <= '0;
      reg_addr     <= '0;
      reg_wdata    <= '0;
      mcu.mcu_dout <= '0;
      mcu.mcu_doe  <= 1'b0;
      mcu.mcu_wait <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      reg_en       <= reg_en_d;
      reg_rd       <= reg_rd_d;
      reg_wr       <= reg_wr_d;
      reg_be       <= reg_be_d;
      reg_addr     <= reg_addr_d;
      reg_wdata    <= reg_wdata_d;
      mcu.mcu_dout <= dout_d;
      mcu.mcu_doe  <= doe_d;
      mcu.mcu_wait <= wait_d;
      proto_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_mcu_reg_bridge.sv
// Scoreboard bench for mcu_reg_bridge: stimulus queues expected accesses,
// a register-file monitor pops and checks each completed access.
`timescale 1ns/1ps
module tb_mcu_reg_bridge;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          reg_en;
  logic          reg_rd;
  logic          reg_wr;
  logic [1:0]    reg_be;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          proto_err;
  logic          err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  mcu_reg_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mcu ();

  mcu_reg_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .STROBE_CYCLES (2),
    .SYNC_STAGES   (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mcu       (mcu),
    .reg_en    (reg_en),
    .reg_rd    (reg_rd),
    .reg_wr    (reg_wr),
    .reg_be    (reg_be),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .proto_err (proto_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Expected access: for writes exp is the register content afterwards, for reads the returned data.
  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];

  // Register-file model: latches on en&rd rise, commits on wr fall.
  logic [15:0] mem [256];
  logic [15:0] rdata_q = '0;
  assign reg_rdata = rdata_q;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
  end

  always @(posedge reg_rd) begin
    if (reg_en) rdata_q = mem[reg_addr];
  end

  always @(negedge reg_wr) begin
    if (reset && reg_en) begin
      if (reg_be[0]) mem[reg_addr][7:0]  = reg_wdata[7:0];
      if (reg_be[1]) mem[reg_addr][15:8] = reg_wdata[15:8];
    end
  end

  // Monitor: profile each reg_en window and score it when reg_en falls.
  bit          in_acc = 1'b0;
  bit          saw_rd;
  bit          saw_wr;
  int          lead;
  int          len;
  int          tail;
  logic [7:0]  c_addr;
  logic [1:0]  c_be;
  logic [15:0] c_wdata;
  exp_t        e;

  always @(negedge clk) begin
    if (!reset) begin
      in_acc = 1'b0;
    end else begin
      if (reg_en && !in_acc) begin
        in_acc = 1'b1; lead = 0; len = 0; tail = 0; saw_rd = 1'b0; saw_wr = 1'b0;
      end
      if (in_acc && reg_en) begin
        if (reg_rd || reg_wr) begin
          chk("rd_wr_exclusive", 32'(reg_rd & reg_wr), 32'd0);
          len++;
          saw_rd  = saw_rd | reg_rd;
          saw_wr  = saw_wr | reg_wr;
          c_addr  = reg_addr;
          c_be    = reg_be;
          c_wdata = reg_wdata;
        end else if (len == 0) begin
          lead++;
        end else begin
          tail++;
        end
      end else if (in_acc) begin
        in_acc = 1'b0;
        if (sb_q.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("dir_wr", 32'(saw_wr), 32'(e.wr));
          chk("dir_rd", 32'(saw_rd), 32'(!e.wr));
          chk("reg_addr", 32'(c_addr), 32'(e.addr));
          chk("reg_be", 32'(c_be), 32'(e.be));
          chk("strobe_len", 32'(len), 32'd2);
          chk("en_lead", 32'(lead), 32'd1);
          chk("en_tail", 32'(tail), 32'd1);
          chk("wait_low_at_end", 32'(mcu.mcu_wait), 32'd0);
          if (e.wr) begin
            chk("reg_wdata", 32'(c_wdata), 32'(e.wdata));
            chk("regfile_content", 32'(mem[e.addr]), 32'(e.exp));
          end else begin
            chk("mcu_dout", 32'(mcu.mcu_dout), 32'(e.exp));
            chk("mcu_doe", 32'(mcu.mcu_doe), 32'd1);
          end
        end
      end
    end
  end

  task automatic release_strobes();
    mcu.mcu_ncs = 1'b1;
    mcu.mcu_nrd = 1'b1;
    mcu.mcu_nwr = 1'b1;
  endtask

  task automatic drive(input bit wr, input logic [7:0] addr, input logic [1:0] be, input logic [15:0] din);
    mcu.mcu_addr = addr;
    mcu.mcu_be   = be;
    mcu.mcu_din  = din;
    mcu.mcu_ncs  = 1'b0;
    if (wr) mcu.mcu_nwr = 1'b0;
    else    mcu.mcu_nrd = 1'b0;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!mcu.mcu_wait && n < 10);
    chk("wait_rise_latency", 32'(n), 32'd3);
  endtask

  // One complete MCU access; early releases the strobe right after E2.
  task automatic access(input bit wr, input logic [7:0] addr, input logic [1:0] be,
                        input logic [15:0] din, input logic [15:0] exp, input bit early);
    int n;
    sb_q.push_back('{wr, addr, be, din, exp});
    @(posedge clk); #2;
    drive(wr, addr, be, din);
    wait_rise(n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (early && n == 2) release_strobes();
    end while (mcu.mcu_wait && n < 12);
    chk("wait_fall_latency", 32'(n), 32'd4);
    release_strobes();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (!wr) chk("doe_after_release", 32'(mcu.mcu_doe), (i < 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    release_strobes();
    mcu.mcu_addr = '0;
    mcu.mcu_be   = '0;
    mcu.mcu_din  = '0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_ctrl", 32'({reg_en, reg_rd, reg_wr, mcu.mcu_doe, mcu.mcu_wait, proto_err}), 32'd0);
    chk("rst_addr_be", 32'({reg_addr, reg_be}), 32'd0);
    chk("rst_data", {reg_wdata, mcu.mcu_dout}, 32'd0);
    #2 reset = 1'b1;

    // Full and byte-lane writes with read-back
    access(1'b1, 8'h05, 2'b11, 16'hBEEF, 16'hBEEF, 1'b0);
    access(1'b0, 8'h05, 2'b11, 16'h0000, 16'hBEEF, 1'b0);
    access(1'b1, 8'h05, 2'b01, 16'h1234, 16'hBE34, 1'b0);
    access(1'b0, 8'h05, 2'b11, 16'h0000, 16'hBE34, 1'b0);
    access(1'b1, 8'h05, 2'b10, 16'hCAFE, 16'hCA34, 1'b0);

    // Both strobes together: error only, no register access
    @(posedge clk); #2;
    mcu.mcu_ncs = 1'b0; mcu.mcu_nrd = 1'b0; mcu.mcu_nwr = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("proto_err_set", 32'(proto_err), 32'd1);
    chk("proto_no_wait", 32'(mcu.mcu_wait), 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("proto_no_access", 32'({reg_en, reg_rd, reg_wr}), 32'd0);
    release_strobes();
    repeat (4) @(posedge clk); #1;
    chk("proto_err_sticky", 32'(proto_err), 32'd1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    chk("proto_err_cleared", 32'(proto_err), 32'd0);

    // Set and clear in the same cycle: set wins, then the held clear removes it
    @(posedge clk); #2;
    mcu.mcu_ncs = 1'b0; mcu.mcu_nrd = 1'b0; mcu.mcu_nwr = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("proto_set_wins", 32'(proto_err), 32'd1);
    @(posedge clk); #1;
    chk("proto_clr_next", 32'(proto_err), 32'd0);
    err_clr = 1'b0;
    release_strobes();
    repeat (4) @(posedge clk);

    // Strobe released mid-access, then a normal read
    access(1'b1, 8'h10, 2'b11, 16'h5A5A, 16'h5A5A, 1'b1);
    access(1'b0, 8'h10, 2'b11, 16'h0000, 16'h5A5A, 1'b0);

    // Asynchronous reset during the write strobe
    @(posedge clk); #2;
    drive(1'b1, 8'h20, 2'b11, 16'hDEAD);
    wait_rise(n);
    repeat (2) @(posedge clk); #1;
    chk("wr_high_before_reset", 32'(reg_wr), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'({reg_en, reg_rd, reg_wr, mcu.mcu_doe, mcu.mcu_wait, proto_err}), 32'd0);
    chk("async_rst_addr_be", 32'({reg_addr, reg_be}), 32'd0);
    chk("async_rst_data", {reg_wdata, mcu.mcu_dout}, 32'd0);
    release_strobes();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_after_reset", 32'({reg_en, mcu.mcu_wait}), 32'd0);
    end
    access(1'b0, 8'h05, 2'b11, 16'h0000, 16'hCA34, 1'b0);

    repeat (3) @(posedge clk); #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
